ctrl_pipeline: RTL

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipe_pkg.sv | 40 ++++
 rtl/ctrl_hazard_unit.sv | 41 ++++
 rtl/ctrl_pipeline.sv | 91 +++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-word layout, stage records, bubbles and forwarding codes for ctrl_pipeline (CTRL_PIPELINE_FWD_EN aware)
package ctrl_pipe_pkg;
  localparam int CTRL_W = 11;
  localparam int EX_W = 9;
  localparam int MM_W = 5;
  localparam int WB_W = 2;
  localparam int ALUOP_HI = 8;
  localparam int ALUOP_LO = 7;
  localparam int MUX4 = 6;
  localparam int MUX5 = 5;
  localparam int MEMR = 4;
  localparam int MEMW = 3;
  localparam int PCSEL = 2;
  localparam int REGW = 1;
  localparam int MUX6 = 0;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MM = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
  typedef struct packed {
    logic            valid;
    logic [EX_W-1:0] ctrl;
    logic [4:0]      rd, rs, rt;
  } ex_t;
  typedef struct packed {
    logic            valid;
    logic [MM_W-1:0] ctrl;
    logic [4:0]      rd, rs, rt;
  } mm_t;
  typedef struct packed {
    logic            valid;
    logic [WB_W-1:0] ctrl;
    logic [4:0]      rd, rs, rt;
  } wb_t;
  localparam ex_t EX_BUBBLE = '0;
  localparam mm_t MM_BUBBLE = '0;
  localparam wb_t WB_BUBBLE = '0;
  function automatic logic reads(input logic [4:0] r, input logic use_r, input logic [4:0] d);
    return use_r && r != 5'd0 && r == d;
  endfunction
endpackage

// File: rtl/ctrl_hazard_unit.sv
// ctrl_hazard_unit: combinational stall detect; with CTRL_PIPELINE_FWD_EN also EX operand forwarding selects
module ctrl_hazard_unit
  import ctrl_pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memr,
  input  logic       ex_regw,
  input  logic [4:0] ex_rd,
  input  logic       mm_regw,
  input  logic [4:0] mm_rd,
  input  logic       wb_regw,
  input  logic [4:0] wb_rd,
`ifdef CTRL_PIPELINE_FWD_EN
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
`endif
  output logic       hazard
);
  logic hit_ex;
  assign hit_ex = reads(id_rs, id_use_rs, ex_rd) || reads(id_rt, id_use_rt, ex_rd);
`ifdef CTRL_PIPELINE_FWD_EN
  logic unused;
  function automatic logic [1:0] src(input logic [4:0] r);
    return reads(r, mm_regw, mm_rd) ? FWD_MM : reads(r, wb_regw, wb_rd) ? FWD_WB : FWD_RF;
  endfunction
  assign unused = ex_regw;
  assign fwd_a = src(ex_rs);
  assign fwd_b = src(ex_rt);
  assign hazard = ex_memr && hit_ex;
`else
  logic hit_mm, hit_wb;
  assign hit_mm = reads(id_rs, id_use_rs, mm_rd) || reads(id_rt, id_use_rt, mm_rd);
  assign hit_wb = reads(id_rs, id_use_rs, wb_rd) || reads(id_rt, id_use_rt, wb_rd);
  assign hazard = ((ex_memr || ex_regw) && hit_ex) || (mm_regw && hit_mm) || (wb_regw && hit_wb);
`endif
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: EX/MM/WB control pipeline with load-use/RAW stall, jump flush, memory freeze; CTRL_PIPELINE_FWD_EN adds fwd_a/fwd_b
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_rd,
  input  logic              mem_stall,
  output logic              id_stall,
  output logic              flush,
  output logic [1:0]        ex_aluop,
  output logic              ex_mux4,
  output logic              ex_mux5,
  output logic              mm_memr,
  output logic              mm_memw,
  output logic              mm_pcsel,
  output logic              wb_regw,
  output logic              wb_mux6,
  output logic [4:0]        ex_rd,
  output logic [4:0]        mm_rd,
`ifdef CTRL_PIPELINE_FWD_EN
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`endif
  output logic [4:0]        wb_rd
);
  ex_t ex, ex_n;
  mm_t mm, mm_n;
  wb_t wb, wb_n;
  logic hazard, ex_regw, mm_regw, unused;
  assign unused = ^{id_ctrl[CTRL_W-1:EX_W], wb.rs, wb.rt};
  assign ex_aluop = ex.valid ? ex.ctrl[ALUOP_HI:ALUOP_LO] : 2'b00;
  assign ex_mux4 = ex.valid && ex.ctrl[MUX4];
  assign ex_mux5 = ex.valid && ex.ctrl[MUX5];
  assign ex_regw = ex.valid && ex.ctrl[REGW];
  assign ex_rd = ex.valid ? ex.rd : 5'd0;
  assign mm_memr = mm.valid && mm.ctrl[MEMR];
  assign mm_memw = mm.valid && mm.ctrl[MEMW];
  assign mm_pcsel = mm.valid && mm.ctrl[PCSEL];
  assign mm_regw = mm.valid && mm.ctrl[REGW];
  assign mm_rd = mm.valid ? mm.rd : 5'd0;
  assign wb_regw = wb.valid && wb.ctrl[REGW];
  assign wb_mux6 = wb.valid && wb.ctrl[MUX6];
  assign wb_rd = wb.valid ? wb.rd : 5'd0;
  assign flush = !mem_stall && mm_pcsel;
  assign id_stall = mem_stall || (!flush && hazard);
  ctrl_hazard_unit u_hazard (
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .ex_memr(ex.valid && ex.ctrl[MEMR]),
    .ex_regw(ex_regw),
    .ex_rd(ex_rd),
    .mm_regw(mm_regw),
    .mm_rd(mm_rd),
    .wb_regw(wb_regw),
    .wb_rd(wb_rd),
`ifdef CTRL_PIPELINE_FWD_EN
    .ex_rs(ex.valid ? ex.rs : 5'd0),
    .ex_rt(ex.valid ? ex.rt : 5'd0),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
`endif
    .hazard(hazard)
  );
  // next stage contents: a taken jump squashes ID and EX; hazards and empty ID slots enter EX as bubbles
  always_comb begin
    ex_n = (flush || hazard || !id_valid) ? EX_BUBBLE : ex_t'({1'b1, id_ctrl[EX_W-1:0], id_rd, id_rs, id_rt});
    mm_n = flush ? MM_BUBBLE : mm_t'({ex.valid, ex.ctrl[MM_W-1:0], ex.rd, ex.rs, ex.rt});
    wb_n = wb_t'({mm.valid, mm.ctrl[WB_W-1:0], mm.rd, mm.rs, mm.rt});
  end
  // stage registers: cleared at once by reset, frozen while data memory is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex <= EX_BUBBLE;
      mm <= MM_BUBBLE;
      wb <= WB_BUBBLE;
    end else if (!mem_stall) begin
      ex <= ex_n;
      mm <= mm_n;
      wb <= wb_n;
    end
  end
endmodule
